vdp_port_ctrl: RTL and testbench
================================

# vdp_port_ctrl

CPU-side port controller for the VDP: decodes I/O accesses to the data port (0x98) and control port (0x99), maintains the two-byte address/register latch, the 14-bit VRAM address pointer, the read-ahead buffer and the eight VDP mode registers. It sequences single-beat VRAM read/write requests into the video block's VRAM, which grants them in free fetch slots. It also returns the status byte and raises a clear strobe toward the video block. It sits between the Z80 I/O decode and the video/VRAM block, replacing ad-hoc port logic in the top level.

## Interface
Parameters:
- ADDR_W, 14, VRAM address width; pointer wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_en  in  1  one-cycle strobe qualifying port_wr/port_rd; one strobe per CPU I/O access.
- port_wr  in  1  CPU I/O write to a VDP port.
- port_rd  in  1  CPU I/O read from a VDP port.
- port_sel  in  1  0 = data port 0x98, 1 = control port 0x99.
- din  in  8  CPU write data.
- dout  out  8  CPU read data, combinational. port_sel=0 gives the read-ahead buffer. port_sel=1 gives {int_flag, fifth_flag, coll_flag, sprite5}.
- int_flag, fifth_flag, coll_flag  in  1 each  status bits from the video block.
- sprite5  in  5  fifth-sprite number from the video block.
- status_clr  out  1  one-cycle pulse when a status read is accepted.
- vram_req  out  1  VRAM access request; held until acknowledged.
- vram_we  out  1  1 = write, 0 = read; stable while vram_req is high.
- vram_addr  out  ADDR_W  access address; stable while vram_req is high.
- vram_wdata  out  8  write data; stable while vram_req is high.
- vram_ack  in  1  one-cycle grant. Completes the access. For reads, vram_rdata is valid in the same cycle.
- vram_rdata  in  8  read data.
- regs  out  64  mode registers R0..R7, R0 in bits [7:0].
- cpu_wait_n  out  1  active-low CPU wait.

## Operation
- State machine: IDLE and PEND.
  - IDLE to PEND when a request is issued.
  - PEND to IDLE on vram_ack, unless a new request is issued in the same cycle.
- Accepted access: io_en & (port_wr | port_rd), not stalled.
- Control port write, toggle=0:
  - first <= din; toggle <= 1.
- Control port write, toggle=1:
  - toggle <= 0.
  - din[7]=1: regs[din[2:0]] <= first, only if din[5:3]==0; otherwise ignored.
  - din[7]=0: ptr <= {din[5:0], first}.
  - din[7]=0 and din[6]=0: additionally issue a prefetch read at the new ptr, then ptr+1.
- Data port write:
  - toggle <= 0; rbuf <= din.
  - Issue a write of din at ptr; ptr <= ptr+1.
- Data port read:
  - toggle <= 0; the CPU receives the current rbuf.
  - Issue a prefetch read at ptr; ptr <= ptr+1.
- Status read (control port read):
  - toggle <= 0; status_clr pulses high the following cycle.
- Issue: vram_addr/vram_we/vram_wdata are captured from the current ptr/data, and vram_req <= 1. The pointer increments at issue.
- Read ack: rbuf <= vram_rdata. Write ack: rbuf is unchanged.
- vram_ack while vram_req=0 is ignored.

## Timing
- Reset values:
  - regs, ptr, first, rbuf, vram_addr, vram_wdata = 0.
  - toggle = 0.
  - vram_req, vram_we, status_clr = 0.
  - cpu_wait_n = 1.
  - State IDLE.
- vram_req rises one clk after the accepted strobe.
- Minimum request duration is one cycle when ack arrives in the first cycle req is high.
- Read data is visible on dout the cycle after vram_ack.
- Register and pointer updates are visible one clk after the accepted strobe.
- Pointer wrap: 0x3FFF + 1 = 0x0000. No carry into other state.
- Control-port accesses and register writes are always accepted, including while PEND. They never disturb the in-flight request.
- Simultaneous vram_ack and a new data-port access in the same cycle: the ack completes, the new request is issued, and there is no stall.
- Reset mid-request drops the request immediately (vram_req low asynchronously).

## Configuration
- VDP_PORT_WAIT_EN defined:
  - A data-port access strobed while PEND (and no ack that cycle) is not accepted.
  - cpu_wait_n is driven low combinationally until ack.
  - The CPU holds the access, and it is accepted in the ack cycle.
- VDP_PORT_WAIT_EN undefined:
  - cpu_wait_n is tied to 1.
  - A data-port access while PEND replaces the pending request: the new address, direction and data are used, vram_req stays high, and ptr still increments.
  - The superseded access is lost.

## Test plan
- Control writes 0x34, 0x47, then data write 0xAB -> vram_req with vram_we=1, vram_addr=0x0734, vram_wdata=0xAB; after ack, ptr=0x0735.
- Control writes 0x00, 0x10, ack returns rdata 0x5A -> vram_we=0 at 0x1000; next data read gives dout=0x5A, a new prefetch issues at 0x1001, and ptr=0x1002.
- Control writes 0xE0, 0x81 -> regs[15:8]=0xE0, no VRAM request. Writing 0x12, 0x8F -> all regs unchanged.
- Control write 0x99 then data read (toggle reset), then control writes 0xFF, 0x7F -> write setup to 0x3FFF, no read; data write then ack gives ptr=0x0000.
- Status read with int=1, coll=1, sprite5=0x03 -> dout=0xA3, status_clr high for exactly one cycle.
- Back-to-back data writes with ack delayed 3 cycles -> with VDP_PORT_WAIT_EN, cpu_wait_n low 3 cycles and both writes land at consecutive addresses; without it, only the second write is performed.

Source files
------------

// File: rtl/vdp_port_ctrl.sv
// VDP CPU port controller: data/control port decode, address latch, VRAM pointer,
// read-ahead buffer, mode registers and single-beat VRAM request sequencing.
// Optional `VDP_PORT_WAIT_EN: stall data-port accesses via cpu_wait_n while a VRAM access is pending.
module vdp_port_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              io_en_i,
  input  logic              port_wr_i,
  input  logic              port_rd_i,
  input  logic              port_sel_i,
  input  logic [7:0]        din_i,
  output logic [7:0]        dout_o,
  input  logic              int_flag_i,
  input  logic              fifth_flag_i,
  input  logic              coll_flag_i,
  input  logic [4:0]        sprite5_i,
  output logic              status_clr_o,
  output logic              vram_req_o,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [7:0]        vram_wdata_o,
  input  logic              vram_ack_i,
  input  logic [7:0]        vram_rdata_i,
  output logic [63:0]       regs_o,
  output logic              cpu_wait_n_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                toggle_q, toggle_d;
  logic [7:0]          first_q, first_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          rbuf_q, rbuf_d;
  logic [7:0]          regs_q [8];
  logic [7:0]          regs_d [8];
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                status_clr_q, status_clr_d;

  logic                pend;
  logic                ack;
  logic                stall;
  logic                accept;
  logic                issue;
  logic                issue_we;
  logic [ADDR_W-1:0]   issue_addr;
  logic [ADDR_W-1:0]   setup_addr;

  assign pend       = (state_q == ST_PEND);
  assign ack        = pend & vram_ack_i;
  assign setup_addr = ADDR_W'({din_i[5:0], first_q});

`ifdef VDP_PORT_WAIT_EN
  // Only data-port accesses wait; the ack cycle itself lets the held access through.
  assign stall        = ~port_sel_i & pend & ~vram_ack_i;
  assign cpu_wait_n_o = ~(pend & ~vram_ack_i);
`else
  assign stall        = 1'b0;
  assign cpu_wait_n_o = 1'b1;
`endif

  assign accept = io_en_i & (port_wr_i | port_rd_i) & ~stall;

  always_comb begin
    state_d      = state_q;
    toggle_d     = toggle_q;
    first_d      = first_q;
    ptr_d        = ptr_q;
    rbuf_d       = rbuf_q;
    regs_d       = regs_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    status_clr_d = 1'b0;
    issue        = 1'b0;
    issue_we     = 1'b0;
    issue_addr   = ptr_q;

    if (ack) begin
      state_d = ST_IDLE;
      if (!we_q) begin
        rbuf_d = vram_rdata_i;
      end
    end

    if (accept) begin
      if (port_sel_i) begin
        if (port_wr_i) begin
          if (!toggle_q) begin
            first_d  = din_i;
            toggle_d = 1'b1;
          end else begin
            toggle_d = 1'b0;
            if (din_i[7]) begin
              if (din_i[5:3] == 3'd0) begin
                regs_d[din_i[2:0]] = first_q;
              end
            end else if (!din_i[6] && (!pend || ack)) begin
              issue      = 1'b1;
              issue_addr = setup_addr;
              ptr_d      = setup_addr + ADDR_W'(1);
            end else begin
              // A read setup arriving mid-access only moves the pointer, leaving the in-flight request alone.
              ptr_d = setup_addr;
            end
          end
        end else begin
          toggle_d     = 1'b0;
          status_clr_d = 1'b1;
        end
      end else begin
        toggle_d   = 1'b0;
        issue      = 1'b1;
        issue_addr = ptr_q;
        issue_we   = port_wr_i;
        ptr_d      = ptr_q + ADDR_W'(1);
        if (port_wr_i) begin
          rbuf_d = din_i;
        end
      end
    end

    if (issue) begin
      state_d = ST_PEND;
      addr_d  = issue_addr;
      we_d    = issue_we;
      if (issue_we) begin
        wdata_d = din_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      toggle_q     <= 1'b0;
      first_q      <= 8'h00;
      ptr_q        <= '0;
      rbuf_q       <= 8'h00;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= 8'h00;
      status_clr_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      toggle_q     <= toggle_d;
      first_q      <= first_d;
      ptr_q        <= ptr_d;
      rbuf_q       <= rbuf_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      status_clr_q <= status_clr_d;
      regs_q       <= regs_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_regs
      assign regs_o[gi*8 +: 8] = regs_q[gi];
    end
  endgenerate

  assign dout_o       = port_sel_i ? {int_flag_i, fifth_flag_i, coll_flag_i, sprite5_i} : rbuf_q;
  assign status_clr_o = status_clr_q;
  assign vram_req_o   = pend;
  assign vram_we_o    = we_q;
  assign vram_addr_o  = addr_q;
  assign vram_wdata_o = wdata_q;

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Self-checking bench for vdp_port_ctrl: transaction-level model compared every cycle,
// plus literal expectations taken from the directed scenarios.
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_en = 1'b0, port_wr = 1'b0, port_rd = 1'b0, port_sel = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        int_f = 1'b0, fifth_f = 1'b0, coll_f = 1'b0;
  logic [4:0]  spr5 = 5'd0;
  logic        status_clr, vram_req, vram_we, cpu_wait_n;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack = 1'b0;
  logic [7:0]  vram_rdata = 8'h00;
  logic [63:0] regs;

  int total = 0;
  int bad   = 0;

  vdp_port_ctrl #(.ADDR_W(14)) dut (
    .clk_i(clk), .reset_i(rst), .io_en_i(io_en), .port_wr_i(port_wr), .port_rd_i(port_rd),
    .port_sel_i(port_sel), .din_i(din), .dout_o(dout), .int_flag_i(int_f),
    .fifth_flag_i(fifth_f), .coll_flag_i(coll_f), .sprite5_i(spr5),
    .status_clr_o(status_clr), .vram_req_o(vram_req), .vram_we_o(vram_we),
    .vram_addr_o(vram_addr), .vram_wdata_o(vram_wdata), .vram_ack_i(vram_ack),
    .vram_rdata_i(vram_rdata), .regs_o(regs), .cpu_wait_n_o(cpu_wait_n)
  );

  always #5 clk = ~clk;

  // Behavioural model: state as the CPU programmer sees it.
  logic [7:0]  m_regs [8];
  logic [13:0] m_ptr, m_addr;
  logic [7:0]  m_first, m_rbuf, m_wdata;
  logic        m_toggle, m_req, m_we, m_status_clr, m_accepted;
  int          m_wr_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_addr = 0; m_first = 0; m_rbuf = 0; m_wdata = 0;
    m_toggle = 0; m_req = 0; m_we = 0; m_status_clr = 0; m_accepted = 0;
  endtask

  task automatic model_issue(input logic we, input logic [13:0] a, input logic [7:0] d);
    m_req  = 1;
    m_we   = we;
    m_addr = a;
    if (we) m_wdata = d;
  endtask

  task automatic model_update();
    logic stall;
    logic [13:0] sa;
    m_status_clr = 0;
    m_accepted   = 0;
    if (rst) begin
      model_reset();
      return;
    end
    stall = 0;
`ifdef VDP_PORT_WAIT_EN
    stall = !port_sel && m_req && !vram_ack;
`endif
    if (vram_ack && m_req) begin
      if (m_we) m_wr_count++;
      else m_rbuf = vram_rdata;
      m_req = 0;
    end
    if (io_en && (port_wr || port_rd) && !stall) begin
      m_accepted = 1;
      if (port_sel && port_wr) begin
        if (!m_toggle) begin
          m_first  = din;
          m_toggle = 1;
        end else begin
          m_toggle = 0;
          if (din[7]) begin
            if (din[5:3] == 3'd0) m_regs[din[2:0]] = m_first;
          end else begin
            sa = {din[5:0], m_first};
            if (!din[6] && !m_req) begin
              model_issue(0, sa, 8'h00);
              m_ptr = sa + 14'd1;
            end else begin
              m_ptr = sa;
            end
          end
        end
      end else if (port_sel) begin
        m_toggle     = 0;
        m_status_clr = 1;
      end else begin
        m_toggle = 0;
        if (port_wr) m_rbuf = din;
        model_issue(port_wr, m_ptr, din);
        m_ptr = m_ptr + 14'd1;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    model_update();
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [63:0] exp_regs;
    logic        exp_wait;
    for (int i = 0; i < 8; i++) exp_regs[i*8 +: 8] = m_regs[i];
    exp_wait = 1'b1;
`ifdef VDP_PORT_WAIT_EN
    exp_wait = !(m_req && !vram_ack);
`endif
    check("req", vram_req, m_req);
    check("wait_n", cpu_wait_n, exp_wait);
    check("status_clr", status_clr, m_status_clr);
    check("regs", regs, exp_regs);
    check("dout", dout, port_sel ? {int_f, fifth_f, coll_f, spr5} : m_rbuf);
    if (m_req) begin
      check("vram_addr", vram_addr, m_addr);
      check("vram_we", vram_we, m_we);
      if (m_we) check("vram_wdata", vram_wdata, m_wdata);
    end
  end

  int wait_low_cnt = 0;
  logic count_wait = 1'b0;
  always @(negedge clk) if (count_wait && !cpu_wait_n) wait_low_cnt++;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    $display("ctrl_wr  %02h", d);
    io_en = 1; port_wr = 1; port_sel = 1; din = d;
    tick();
    io_en = 0; port_wr = 0; port_sel = 0;
  endtask

  task automatic data_wr(input logic [7:0] d);
    $display("data_wr  %02h", d);
    io_en = 1; port_wr = 1; port_sel = 0; din = d;
    tick();
    io_en = 0; port_wr = 0;
  endtask

  task automatic data_rd();
    $display("data_rd  dout=%02h", dout);
    io_en = 1; port_rd = 1; port_sel = 0;
    tick();
    io_en = 0; port_rd = 0;
  endtask

  task automatic ack(input logic [7:0] rd);
    $display("vram_ack rdata=%02h", rd);
    vram_ack = 1; vram_rdata = rd;
    tick();
    vram_ack = 0;
  endtask

  initial begin
    int n;
    model_reset();
    m_wr_count = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", vram_req, 1'b0);
    check("rst_wait_n", cpu_wait_n, 1'b1);
    check("rst_regs", regs, 64'h0);
    check("rst_dout", dout, 8'h00);
    check("rst_addr", vram_addr, 14'h0);
    @(posedge clk); #2;
    rst = 0;
    tick();

    // Write setup then data write
    ctrl_wr(8'h34); ctrl_wr(8'h47); data_wr(8'hAB);
    check("t1_req", vram_req, 1'b1);
    check("t1_we", vram_we, 1'b1);
    check("t1_addr", vram_addr, 14'h0734);
    check("t1_wdata", vram_wdata, 8'hAB);
    tick(); ack(8'h00);
    data_rd();
    check("t1_ptr", vram_addr, 14'h0735);
    ack(8'h11);

    // Read setup with prefetch
    ctrl_wr(8'h00); ctrl_wr(8'h10);
    check("t2_we", vram_we, 1'b0);
    check("t2_addr", vram_addr, 14'h1000);
    ack(8'h5A);
    check("t2_dout", dout, 8'h5A);
    data_rd();
    check("t2_addr2", vram_addr, 14'h1001);
    ack(8'h77);
    data_rd();
    check("t2_ptr", vram_addr, 14'h1002);
    ack(8'h33);

    // Register writes
    ctrl_wr(8'hE0); ctrl_wr(8'h81);
    check("t3_r1", regs, 64'h0000_0000_0000_E000);
    check("t3_noreq", vram_req, 1'b0);
    ctrl_wr(8'h12); ctrl_wr(8'h8F);
    check("t3_ignored", regs, 64'h0000_0000_0000_E000);

    // Toggle reset by data read, write setup at top of VRAM, wrap
    ctrl_wr(8'h99); data_rd(); ack(8'h44);
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    check("t4_noread", vram_req, 1'b0);
    data_wr(8'h42);
    check("t4_addr", vram_addr, 14'h3FFF);
    ack(8'h00);
    data_rd();
    check("t4_wrap", vram_addr, 14'h0000);
    ack(8'h55);

    // Status read
    int_f = 1; coll_f = 1; spr5 = 5'h03;
    port_sel = 1;
    @(negedge clk);
    check("t5_dout", dout, 8'hA3);
    @(posedge clk); #2;
    $display("status_rd dout=%02h", dout);
    io_en = 1; port_rd = 1; port_sel = 1;
    tick();
    io_en = 0; port_rd = 0; port_sel = 0;
    @(negedge clk);
    check("t5_clr_hi", status_clr, 1'b1);
    @(negedge clk);
    check("t5_clr_lo", status_clr, 1'b0);
    int_f = 0; coll_f = 0; spr5 = 5'h00;
    tick();

    // Back-to-back data writes with a delayed ack
    ctrl_wr(8'h00); ctrl_wr(8'h42);
    m_wr_count = 0;
`ifdef VDP_PORT_WAIT_EN
    count_wait = 1;
    data_wr(8'h11);
    fork
      begin
        io_en = 1; port_wr = 1; port_sel = 0; din = 8'h22;
        n = 0;
        do begin tick(); n++; end while (!m_accepted && n < 20);
        io_en = 0; port_wr = 0;
        if (!m_accepted) check("t6_wait_timeout", 1'b0, 1'b1);
      end
      begin
        repeat (3) tick();
        vram_ack = 1; vram_rdata = 8'h00;
        tick();
        vram_ack = 0;
      end
    join
    count_wait = 0;
    check("t6_wait_cycles", wait_low_cnt, 3);
    check("t6_addr2", vram_addr, 14'h0201);
    ack(8'h00);
    check("t6_writes", m_wr_count, 2);
`else
    n = 0;
    data_wr(8'h11);
    data_wr(8'h22);
    check("t6_addr", vram_addr, 14'h0201);
    check("t6_wdata", vram_wdata, 8'h22);
    tick(); tick();
    ack(8'h00);
    check("t6_done", vram_req, 1'b0);
    check("t6_writes", m_wr_count, 1);
`endif

    // Reset in the middle of a request
    data_wr(8'h66);
    check("t7_req", vram_req, 1'b1);
    rst = 1;
    model_reset();
    #1;
    check("t7_async_drop", vram_req, 1'b0);
    tick(); tick();
    rst = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
